regfile_32x64: RTL and testbench

REGFILE_32X64 -- requirements
Module: regfile_32x64

---
 rtl/regfile_if.sv | 24 ++
 rtl/regfile_32x64.sv | 70 +++++++
 tb/tb_regfile_32x64.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Register-file access bundle: one write port, two combinational read ports.
//   master : drives write/read requests, receives ReadData1/ReadData2
//   slave  : the register file itself
interface regfile_if #(
  parameter int WIDTH = 64
);
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_32x64.sv
// 32-entry register file: X0..X30 stored, index 31 is XZR (always reads 0).
// One write port (one-hot decoded, enable-muxed flops), two combinational
// read ports with optional same-cycle write forwarding (BYPASS).
//   clk     : rising-edge clock for all register state
//   reset_n : async active-low clear of X0..X30; blocks writes and forwarding
//   bus     : regfile_if slave (write port + two read ports)

// One storage element: D flop with a hold mux, async clear.
module regfile_32x64_cell #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (en)   q <= d;
  end
endmodule

module regfile_32x64 #(
  parameter int WIDTH  = 64,
  parameter int BYPASS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  regfile_if.slave   bus
);
  localparam bit BYP = (BYPASS != 0);

  // Writes (and forwarding of write data) are suppressed while reset is held,
  // so every read port shows 0 for the whole reset window.
  logic                        wr_en;
  logic [30:0]                 wr_sel;
  logic [31:0][WIDTH-1:0]      regs;
  logic                        byp1, byp2;

  assign wr_en = bus.RegWrite & reset_n;

  // 5-to-32 one-hot decode; entry 31 has no storage so it is never decoded.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < 31; i++)
      wr_sel[i] = wr_en && (bus.WriteRegister == 5'(i));
  end

  for (genvar i = 0; i < 31; i++) begin : g_reg
    regfile_32x64_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_sel[i]),
      .d       (bus.WriteData),
      .q       (regs[i])
    );
  end

  assign regs[31] = '0;

  // Forward only real writes; a write to XZR must not leak onto a port reading 31.
  assign byp1 = BYP && wr_en && (bus.WriteRegister != 5'd31) &&
                (bus.ReadRegister1 == bus.WriteRegister);
  assign byp2 = BYP && wr_en && (bus.WriteRegister != 5'd31) &&
                (bus.ReadRegister2 == bus.WriteRegister);

  assign bus.ReadData1 = byp1 ? bus.WriteData : regs[bus.ReadRegister1];
  assign bus.ReadData2 = byp2 ? bus.WriteData : regs[bus.ReadRegister2];
endmodule

// File: tb/tb_regfile_32x64.sv
// Bench for regfile_32x64: drives a BYPASS=0 and a BYPASS=1 instance with
// identical stimulus and compares both against an array-based reference.
module tb_regfile_32x64;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_if #(.WIDTH(64)) bus_nb ();
  regfile_if #(.WIDTH(64)) bus_by ();

  regfile_32x64 #(.WIDTH(64), .BYPASS(0)) dut_nb (.clk(clk), .reset_n(reset_n), .bus(bus_nb));
  regfile_32x64 #(.WIDTH(64), .BYPASS(1)) dut_by (.clk(clk), .reset_n(reset_n), .bus(bus_by));

  // index 0: no-bypass instance, index 1: bypass instance
  logic [63:0] rd1 [2];
  logic [63:0] rd2 [2];
  assign rd1[0] = bus_nb.ReadData1;
  assign rd2[0] = bus_nb.ReadData2;
  assign rd1[1] = bus_by.ReadData1;
  assign rd2[1] = bus_by.ReadData2;

  // Reference state and current stimulus
  logic [63:0] mdl [31];
  logic        in_reset;
  logic        cur_we;
  logic [4:0]  cur_wr, cur_r1, cur_r2;
  logic [63:0] cur_wd;

  // Expected read value from the architectural rules.
  function automatic logic [63:0] exp_rd(int byp, logic [4:0] idx);
    if (idx == 5'd31 || in_reset) return 64'd0;
    if (byp != 0 && cur_we && cur_wr != 5'd31 && idx == cur_wr) return cur_wd;
    return mdl[idx];
  endfunction

  task automatic drive(logic we, logic [4:0] wr, logic [63:0] wd, logic [4:0] r1, logic [4:0] r2);
    cur_we = we; cur_wr = wr; cur_wd = wd; cur_r1 = r1; cur_r2 = r2;
    bus_nb.RegWrite = we; bus_nb.WriteRegister = wr; bus_nb.WriteData = wd;
    bus_nb.ReadRegister1 = r1; bus_nb.ReadRegister2 = r2;
    bus_by.RegWrite = we; bus_by.WriteRegister = wr; bus_by.WriteData = wd;
    bus_by.ReadRegister1 = r1; bus_by.ReadRegister2 = r2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 31; i++) mdl[i] = 64'd0;
  endtask

  // Advance one rising edge and apply the write to the reference.
  task automatic step_edge();
    @(posedge clk);
    if (!in_reset && cur_we && cur_wr != 5'd31) mdl[cur_wr] = cur_wd;
    #1;
  endtask

  task automatic sweep(string name);
    for (int idx = 0; idx < 32; idx++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 5'(idx), 5'(31 - idx));
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rd1[d] !== exp_rd(d, cur_r1)) begin
          errors++;
          $display("FAIL %s dut%0d port1 idx%0d: got %h expected %h", name, d, cur_r1, rd1[d], exp_rd(d, cur_r1));
        end
        checks++;
        if (rd2[d] !== exp_rd(d, cur_r2)) begin
          errors++;
          $display("FAIL %s dut%0d port2 idx%0d: got %h expected %h", name, d, cur_r2, rd2[d], exp_rd(d, cur_r2));
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; in_reset = 1'b1; clear_model();
    drive(1'b1, 5'd2, 64'hFFFF, 5'd2, 5'd2);
    step_edge();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'd0) begin
        errors++;
        $display("FAIL reset_hold dut%0d: got %h expected 0", d, rd1[d]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1; in_reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    sweep("reset_sweep");
  endtask

  task automatic test_fill_sweep();
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 64'hA5A5_0000_0000_0000 + 64'(i), 5'(i), 5'd31);
      step_edge();
    end
    // Independent constant check on a couple of entries
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd30);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'hA5A5_0000_0000_0000 || rd2[d] !== 64'hA5A5_0000_0000_001E) begin
        errors++;
        $display("FAIL fill_const dut%0d: got %h/%h expected a5a5000000000000/a5a500000000001e", d, rd1[d], rd2[d]);
      end
    end
    sweep("fill_sweep");
  endtask

  task automatic test_xzr();
    @(negedge clk);
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'd0 || rd2[d] !== 64'd0) begin
        errors++;
        $display("FAIL xzr_same_cycle dut%0d: got %h/%h expected 0", d, rd1[d], rd2[d]);
      end
    end
    step_edge();
    sweep("xzr_sweep");
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    drive(1'b0, 5'd5, 64'h1234, 5'd5, 5'd5);
    step_edge();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'hA5A5_0000_0000_0005) begin
        errors++;
        $display("FAIL write_disabled dut%0d: got %h expected a5a5000000000005", d, rd1[d]);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 5'd7, 64'h1, 5'd0, 5'd0);
    step_edge();
    @(negedge clk);
    drive(1'b1, 5'd7, 64'h2, 5'd7, 5'd7);
    #1;
    checks++;
    if (rd1[1] !== 64'h2 || rd2[1] !== 64'h2) begin
      errors++;
      $display("FAIL bypass_before_edge dut1: got %h/%h expected 2", rd1[1], rd2[1]);
    end
    checks++;
    if (rd1[0] !== 64'h1 || rd2[0] !== 64'h1) begin
      errors++;
      $display("FAIL nobypass_before_edge dut0: got %h/%h expected 1", rd1[0], rd2[0]);
    end
    step_edge();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'h2 || rd2[d] !== 64'h2) begin
        errors++;
        $display("FAIL bypass_after_edge dut%0d: got %h/%h expected 2", d, rd1[d], rd2[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 5'd3, 64'hDEAD, 5'd3, 5'd3);
    step_edge();
    @(negedge clk);
    drive(1'b1, 5'd3, 64'hBEEF, 5'd3, 5'd3);
    #2;
    reset_n = 1'b0; in_reset = 1'b1; clear_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'd0) begin
        errors++;
        $display("FAIL async_reset_immediate dut%0d: got %h expected 0", d, rd1[d]);
      end
    end
    step_edge();
    @(negedge clk);
    reset_n = 1'b1; in_reset = 1'b0;
    // First edge after release must accept a write
    drive(1'b1, 5'd4, 64'h44, 5'd3, 5'd4);
    step_edge();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd1[d] !== 64'd0) begin
        errors++;
        $display("FAIL reset_write_lost dut%0d: got %h expected 0", d, rd1[d]);
      end
      checks++;
      if (rd2[d] !== 64'h44) begin
        errors++;
        $display("FAIL first_write_after_reset dut%0d: got %h expected 44", d, rd2[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, r1, r2;
      @(negedge clk);
      wr = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wr, {$urandom, $urandom}, r1, r2);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rd1[d] !== exp_rd(d, cur_r1) || rd2[d] !== exp_rd(d, cur_r2)) begin
          errors++;
          $display("FAIL random_pre dut%0d r1=%0d r2=%0d: got %h/%h expected %h/%h", d, cur_r1, cur_r2,
                   rd1[d], rd2[d], exp_rd(d, cur_r1), exp_rd(d, cur_r2));
        end
      end
      step_edge();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rd1[d] !== exp_rd(d, cur_r1) || rd2[d] !== exp_rd(d, cur_r2)) begin
          errors++;
          $display("FAIL random_post dut%0d r1=%0d r2=%0d: got %h/%h expected %h/%h", d, cur_r1, cur_r2,
                   rd1[d], rd2[d], exp_rd(d, cur_r1), exp_rd(d, cur_r2));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_reset = 1'b1;
    clear_model();
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    test_reset();
    test_fill_sweep();
    test_xzr();
    test_write_disabled();
    test_bypass();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
